// File: rtl/proc_ctrl_fsm_if.sv
// Handshake bundle between proc_ctrl_fsm (master) and the processor datapath (slave).
// PROC_CTRL_ILLEGAL_TRAP_EN adds the Trap status line.
interface proc_ctrl_fsm_if #(
  parameter int RADDR_W = 3,
  parameter int OPC_W   = 3
);
  localparam int NREG = 2 ** RADDR_W;
  localparam int IR_W = OPC_W + 2 * RADDR_W;

  logic            Run;
  logic [IR_W-1:0] IR;
  logic            IRin;
  logic            DINout;
  logic [NREG-1:0] Rout;
  logic [NREG-1:0] Rin;
  logic            Ain;
  logic            Gin;
  logic            AddSub;
  logic            Gout;
  logic            Done;
  logic [1:0]      Tstep;
`ifdef PROC_CTRL_ILLEGAL_TRAP_EN
  logic            Trap;

  modport master (
    input  Run, IR,
    output IRin, DINout, Rout, Rin, Ain, Gin, AddSub, Gout, Done, Tstep, Trap
  );
  modport slave (
    output Run, IR,
    input  IRin, DINout, Rout, Rin, Ain, Gin, AddSub, Gout, Done, Tstep, Trap
  );
`else
  modport master (
    input  Run, IR,
    output IRin, DINout, Rout, Rin, Ain, Gin, AddSub, Gout, Done, Tstep
  );
  modport slave (
    output Run, IR,
    input  IRin, DINout, Rout, Rin, Ain, Gin, AddSub, Gout, Done, Tstep
  );
`endif
endinterface

// File: rtl/proc_ctrl_fsm.sv
// Instruction sequencer (T0-T3) for the 16-bit bus-based processor datapath.
// Optional macro PROC_CTRL_ILLEGAL_TRAP_EN: illegal opcodes trap into HALT instead of a 1-cycle NOP.
module proc_ctrl_fsm #(
  parameter int RADDR_W = 3,
  parameter int OPC_W   = 3
) (
  input  logic             clk,
  input  logic             Resetn,
  proc_ctrl_fsm_if.master  bus
);
  localparam int NREG = 2 ** RADDR_W;
  localparam int IR_W = OPC_W + 2 * RADDR_W;

  localparam logic [2:0] S_T0   = 3'd0;
  localparam logic [2:0] S_T1   = 3'd1;
  localparam logic [2:0] S_T2   = 3'd2;
  localparam logic [2:0] S_T3   = 3'd3;
`ifdef PROC_CTRL_ILLEGAL_TRAP_EN
  // HALT reports Tstep=3 through its low bits
  localparam logic [2:0] S_HALT = 3'd7;
`endif

  localparam logic [OPC_W-1:0] OP_MV  = OPC_W'(2'd0);
  localparam logic [OPC_W-1:0] OP_MVI = OPC_W'(2'd1);
  localparam logic [OPC_W-1:0] OP_ADD = OPC_W'(2'd2);
  localparam logic [OPC_W-1:0] OP_SUB = OPC_W'(2'd3);

  logic [2:0]         state_q;
  logic [2:0]         state_d;
  logic [OPC_W-1:0]   opc_s;
  logic [RADDR_W-1:0] rx_s;
  logic [RADDR_W-1:0] ry_s;

  logic               irin_s;
  logic               dinout_s;
  logic [NREG-1:0]    rout_s;
  logic [NREG-1:0]    rin_s;
  logic               ain_s;
  logic               gin_s;
  logic               addsub_s;
  logic               gout_s;
  logic               done_s;

  function automatic logic [NREG-1:0] onehot(input logic [RADDR_W-1:0] idx);
    onehot = NREG'(1'b1) << idx;
  endfunction

  assign opc_s = bus.IR[IR_W-1 -: OPC_W];
  assign rx_s  = bus.IR[2*RADDR_W-1 -: RADDR_W];
  assign ry_s  = bus.IR[RADDR_W-1:0];

  // Next-state and enable decode from (state, IR, Run)
  always_comb begin
    state_d  = state_q;
    irin_s   = 1'b0;
    dinout_s = 1'b0;
    rout_s   = '0;
    rin_s    = '0;
    ain_s    = 1'b0;
    gin_s    = 1'b0;
    addsub_s = 1'b0;
    gout_s   = 1'b0;
    done_s   = 1'b0;
    case (state_q)
      S_T0: begin
        irin_s = bus.Run;
        if (bus.Run) begin
          state_d = S_T1;
        end else begin
          state_d = S_T0;
        end
      end
      S_T1: begin
        case (opc_s)
          OP_MV: begin
            rout_s  = onehot(ry_s);
            rin_s   = onehot(rx_s);
            done_s  = 1'b1;
            state_d = S_T0;
          end
          OP_MVI: begin
            dinout_s = 1'b1;
            rin_s    = onehot(rx_s);
            done_s   = 1'b1;
            state_d  = S_T0;
          end
          OP_ADD, OP_SUB: begin
            rout_s  = onehot(rx_s);
            ain_s   = 1'b1;
            state_d = S_T2;
          end
          default: begin
`ifdef PROC_CTRL_ILLEGAL_TRAP_EN
            state_d = S_HALT;
`else
            done_s  = 1'b1;
            state_d = S_T0;
`endif
          end
        endcase
      end
      S_T2: begin
        rout_s   = onehot(ry_s);
        gin_s    = 1'b1;
        addsub_s = opc_s[0];
        state_d  = S_T3;
      end
      S_T3: begin
        gout_s  = 1'b1;
        rin_s   = onehot(rx_s);
        done_s  = 1'b1;
        state_d = S_T0;
      end
`ifdef PROC_CTRL_ILLEGAL_TRAP_EN
      S_HALT: begin
        state_d = S_HALT;
      end
`endif
      default: begin
        state_d = S_T0;
      end
    endcase
  end

  // Timestep register; reset returns to T0 immediately
  always_ff @(posedge clk or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= S_T0;
    end else begin
      state_q <= state_d;
    end
  end

  // Reset masks every enable, including IRin which otherwise follows Run in T0
  assign bus.IRin   = Resetn & irin_s;
  assign bus.DINout = Resetn & dinout_s;
  assign bus.Rout   = {NREG{Resetn}} & rout_s;
  assign bus.Rin    = {NREG{Resetn}} & rin_s;
  assign bus.Ain    = Resetn & ain_s;
  assign bus.Gin    = Resetn & gin_s;
  assign bus.AddSub = Resetn & addsub_s;
  assign bus.Gout   = Resetn & gout_s;
  assign bus.Done   = Resetn & done_s;
  assign bus.Tstep  = state_q[1:0];
`ifdef PROC_CTRL_ILLEGAL_TRAP_EN
  assign bus.Trap   = (state_q == S_HALT);
`endif
endmodule
